// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding, request legality check.
package lsu_pkg;

  localparam int unsigned DefaultAddrLimit = 404;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StStoreW = 3'd2,
    StRmwRd  = 3'd3,
    StRmwWr  = 3'd4
  } lsu_state_e;

  // Unsigned variants exist for loads only; stores reject funct3 4/5.
  function automatic logic lsu_req_err(logic we, logic [2:0] funct3, logic [31:0] addr,
                                       int unsigned limit);
    logic legal;
    logic misaligned;
    legal      = 1'b1;
    misaligned = 1'b0;
    case (funct3)
      F3_B:    ;
      F3_H:    misaligned = addr[0];
      F3_W:    misaligned = |addr[1:0];
      F3_BU:   legal = ~we;
      F3_HU: begin
        legal      = ~we;
        misaligned = addr[0];
      end
      default: legal = 1'b0;
    endcase
    return ~legal | misaligned | (addr >= limit);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extraction/extension and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = word_i[{lane_i, 3'b000} +: 8];
    half_sel    = lane_i[1] ? word_i[31:16] : word_i[15:0];
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data_o = word_i;
      F3_BU:   load_data_o = {24'h0, byte_sel};
      F3_HU:   load_data_o = {16'h0, half_sel};
      default: load_data_o = '0;
    endcase
  end

  always_comb begin
    merged_o = old_i;
    case (funct3_i)
      F3_B:    merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H:    merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      F3_W:    merged_o = wdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts RV32I load/store requests and issues word accesses,
// using read-modify-write for SB/SH. Memory controls are Moore outputs of the state register.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = DefaultAddrLimit
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_RW,
  output logic [31:0] mem_ADDr,
  output logic [31:0] mem_Din,
  input  logic [31:0] mem_Dout
);

  lsu_state_e  state_q, state_d;
  logic        accept;
  logic        req_err;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic        rsp_valid_d, rsp_valid_q;
  logic        rsp_err_d, rsp_err_q;
  logic [31:0] rsp_rdata_d, rsp_rdata_q;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  assign req_err   = lsu_req_err(req_we, req_funct3, req_addr, ADDR_LIMIT);

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  lsu_lane_align u_lane_align (
    .word_i      (mem_Dout),
    .old_i       (old_q),
    .wdata_i     (wdata_q),
    .funct3_i    (funct3_q),
    .lane_i      (addr_q[1:0]),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !req_err) begin
          if (!req_we) begin
            state_d = StLoad;
          end else if (req_funct3 == F3_W) begin
            state_d = StStoreW;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StRmwRd:  state_d = StRmwWr;
      StLoad,
      StStoreW,
      StRmwWr:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Every response is registered so it lands while the FSM is already back in idle.
  always_comb begin
    mem_RW      = 1'b0;
    mem_ADDr    = '0;
    mem_Din     = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (accept && req_err) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      StLoad: begin
        mem_ADDr    = {addr_q[31:2], 2'b00};
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_data;
      end
      StStoreW: begin
        mem_RW      = 1'b1;
        mem_ADDr    = {addr_q[31:2], 2'b00};
        mem_Din     = wdata_q;
        rsp_valid_d = 1'b1;
      end
      StRmwRd: begin
        mem_ADDr = {addr_q[31:2], 2'b00};
      end
      StRmwWr: begin
        mem_RW      = 1'b1;
        mem_ADDr    = {addr_q[31:2], 2'b00};
        mem_Din     = merged;
        rsp_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      old_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == StRmwRd) begin
        old_q <= mem_Dout;
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: load_store_unit paired with a word memory, checked against a byte-array model.
module tb_load_store_unit;

  localparam int unsigned Limit = 404;
  localparam int unsigned Words = 101;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_RW;
  logic [31:0] mem_ADDr;
  logic [31:0] mem_Din;
  logic [31:0] mem_Dout;

  always #5 CLK = ~CLK;

  load_store_unit #(.ADDR_LIMIT(Limit)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_RW     (mem_RW),
    .mem_ADDr   (mem_ADDr),
    .mem_Din    (mem_Din),
    .mem_Dout   (mem_Dout)
  );

  // Data memory: synchronous write, combinational read.
  logic [31:0] mem [Words];
  int unsigned widx;
  always_comb begin
    widx     = 32'(mem_ADDr[31:2]);
    mem_Dout = 32'h0;
    if (widx < Words) mem_Dout = mem[widx];
  end
  always @(posedge CLK) if (mem_RW && widx < Words) mem[widx] <= mem_Din;

  // Reference model: byte-addressed memory.
  logic [7:0] ref_b [Limit];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nw_from = -1;
  int nw_to = -2;
  int last_acc = 0;
  int last_due = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int acc_size(logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_err(logic we, logic [2:0] f3, logic [31:0] a);
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || (a % acc_size(f3)) != 0 || a >= Limit;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
    int n;
    logic [31:0] v;
    n = acc_size(f3);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[int'(a) + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] ref_word(int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < acc_size(f3); i++) ref_b[int'(a) + i] = 8'(wd >> (8 * i));
  endtask

  // Present a request, wait for its acceptance and record the expected response.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit keep);
    int waited;
    int lat;
    exp_t e;
    waited = 0;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready) begin
      if (waited == 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, expected 1", req_ready, waited);
        req_valid = 1'b0;
        return;
      end
      @(posedge CLK); #1;
      waited++;
    end
    @(posedge CLK); #1;
    last_acc = cyc - 1;
    e.err   = ref_err(we, f3, addr);
    e.rdata = 32'h0;
    if (e.err) lat = 1;
    else if (!we) begin
      lat = 2;
      e.rdata = ref_load(f3, addr);
    end else begin
      lat = (f3 == 3'd2) ? 2 : 3;
      ref_store(f3, addr, wd);
    end
    e.due = last_acc + lat;
    if (e.err || !we) begin
      nw_from = last_acc + 1;
      nw_to   = e.due;
    end
    last_due = e.due;
    sb_q.push_back(e);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 50) begin
      @(posedge CLK); #1;
      w++;
    end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: pops one expectation per rsp_valid cycle.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (cyc >= nw_from && cyc <= nw_to) chk("no_write_during_load_or_err", 32'(mem_RW), 32'h0);
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_rsp: rsp_valid=1 with no request outstanding, expected 0");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end else begin
        chk("rdata_idle_zero", rsp_rdata, 32'h0);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
    chk({tag, "_mem_RW"}, 32'(mem_RW), 32'h0);
    chk({tag, "_mem_ADDr"}, mem_ADDr, 32'h0);
    chk({tag, "_mem_Din"}, mem_Din, 32'h0);
  endtask

  initial begin
    logic [31:0] w32;
    int prev_due;
    for (int w = 0; w < int'(Words); w++) begin
      w32 = $urandom;
      mem[w] <= w32;
      for (int b = 0; b < 4; b++) ref_b[4*w+b] = 8'(w32 >> (8 * b));
    end
    #2;
    chk_reset_outputs("por");
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    // Sub-word loads of a stored word
    issue(1'b1, 3'd2, 32'h10, 32'h8000_00FF, 1'b0);
    issue(1'b0, 3'd0, 32'h10, 32'h0, 1'b0);
    issue(1'b0, 3'd4, 32'h13, 32'h0, 1'b0);
    issue(1'b0, 3'd1, 32'h12, 32'h0, 1'b0);
    drain();

    // Read-modify-write merges
    issue(1'b1, 3'd2, 32'h20, 32'h1122_3344, 1'b0);
    issue(1'b1, 3'd0, 32'h21, 32'h0000_00AB, 1'b0);
    drain();
    chk("mem_after_sb", mem[8], 32'h1122_AB44);
    issue(1'b1, 3'd1, 32'h22, 32'h0000_BEEF, 1'b0);
    drain();
    chk("mem_after_sh", mem[8], 32'hBEEF_AB44);

    // Error cases
    issue(1'b0, 3'd2, 32'h06, 32'h0, 1'b0);
    issue(1'b1, 3'd1, 32'h03, 32'h1234_5678, 1'b0);
    issue(1'b0, 3'd3, 32'h00, 32'h0, 1'b0);
    issue(1'b0, 3'd2, 32'd404, 32'h0, 1'b0);
    drain();

    // Back-to-back stream with req_valid held high
    issue(1'b1, 3'd2, 32'h30, 32'hCAFE_F00D, 1'b1);
    prev_due = last_due;
    issue(1'b0, 3'd2, 32'h30, 32'h0, 1'b1);
    chk("b2b_accept_lw", 32'(last_acc), 32'(prev_due));
    prev_due = last_due;
    issue(1'b1, 3'd0, 32'h31, 32'h0000_005A, 1'b1);
    chk("b2b_accept_sb", 32'(last_acc), 32'(prev_due));
    prev_due = last_due;
    issue(1'b0, 3'd2, 32'h30, 32'h0, 1'b0);
    chk("b2b_accept_lw2", 32'(last_acc), 32'(prev_due));
    drain();
    chk("mem_after_b2b", mem[12], 32'hCAFE_5A0D);

    // Reset while in RMW_RD: nothing must be written
    req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h41; req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    #2 RST_N = 1'b0;
    #1 chk_reset_outputs("midop");
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1 chk("mem_unchanged_after_abort", mem[16], ref_word(16));

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          t;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        f3   = 3'($urandom_range(0, 7));
        addr = 32'($urandom_range(0, 420));
      end else begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          t  = int'($urandom_range(0, 4));
          f3 = 3'((t > 2) ? t + 1 : t);
        end
        addr = 32'(4 * $urandom_range(0, 100))
             + (32'($urandom_range(0, 3)) & ~32'(acc_size(f3) - 1));
      end
      issue(we, f3, addr, $urandom, 1'($urandom_range(0, 1)));
      if (!req_valid && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
    end
    req_valid = 1'b0;
    drain();

    for (int w = 0; w < int'(Words); w++) chk("final_mem", mem[w], ref_word(w));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
